// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg : shared types and ALU opcodes for the multi-cycle M-extension unit
// Rev 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mdu_state_e;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } mdu_funct3_e;

  localparam logic [3:0] ALU_OP_ADD = 4'b0010;
  localparam logic [3:0] ALU_OP_SUB = 4'b0110;

  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// alu : combinational integer ALU shared by the EX stage and the MDU
// Rev 1.0
// ============================================================================
`default_nettype none

module alu #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ALUResult
);

  always_comb begin
    ALUResult = '0;
    case (Operation)
      OPCODE_LENGTH'(4'b0000): ALUResult = SrcA & SrcB;
      OPCODE_LENGTH'(4'b0001): ALUResult = SrcA | SrcB;
      OPCODE_LENGTH'(4'b0010): ALUResult = SrcA + SrcB;
      OPCODE_LENGTH'(4'b0110): ALUResult = SrcA - SrcB;
      default:                 ALUResult = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_mdu_seq.sv
// ============================================================================
// alu_mdu_seq : multi-cycle RV32M multiply/divide sequencer on a private alu
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_mdu_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  flush,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  import mdu_pkg::*;

  localparam int W       = DATA_WIDTH;
  localparam int c_cnt_w = $clog2(DATA_WIDTH) + 1;
  localparam logic [DATA_WIDTH-1:0] c_int_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  mdu_state_e         r_state;
  logic [2:0]         r_f3;
  logic [W-1:0]       r_a, r_b, r_acc_hi, r_acc_lo, r_result;
  logic               r_sign_a, r_sign_b;
  logic               r_start_ready, r_result_valid, r_busy;
  logic [c_cnt_w-1:0] r_cnt;

  logic [W:0]               w_alu_a, w_alu_b, w_alu_res, w_rem_sh, w_sum;
  logic [OPCODE_LENGTH-1:0] w_alu_op;
  logic [2*W-1:0]           w_prod, w_prod_fix;
  logic [W-1:0]             w_quo, w_rem, w_fix_res, w_special_res;
  logic                     w_is_div, w_neg_a, w_neg_b, w_div0, w_ovf, w_borrow;

  assign w_is_div = r_f3[2];
  assign w_neg_a  = a_is_signed(r_f3) & r_a[W-1];
  assign w_neg_b  = b_is_signed(r_f3) & r_b[W-1];
  assign w_div0   = w_is_div & (r_b == '0);
  assign w_ovf    = w_is_div & ~r_f3[0] & (r_a == c_int_min) & (&r_b);
  assign w_rem_sh = {r_acc_hi, r_acc_lo[W-1]};
  // Bit W of the W+1-bit alu is the ADD carry / SUB borrow.
  assign w_borrow = w_alu_res[W];
  assign w_sum    = r_acc_lo[0] ? w_alu_res : {1'b0, r_acc_hi};

  always_comb begin
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_alu_op = OPCODE_LENGTH'(ALU_OP_ADD);
    case (r_state)
      PREP: begin
        w_alu_b  = {1'b0, r_a};
        w_alu_op = OPCODE_LENGTH'(ALU_OP_SUB);
      end
      ITER: begin
        if (w_is_div) begin
          w_alu_a  = w_rem_sh;
          w_alu_b  = {1'b0, r_b};
          w_alu_op = OPCODE_LENGTH'(ALU_OP_SUB);
        end else begin
          w_alu_a  = {1'b0, r_acc_hi};
          w_alu_b  = {1'b0, r_a};
        end
      end
      default: ;
    endcase
  end

  alu #(.DATA_WIDTH(DATA_WIDTH + 1), .OPCODE_LENGTH(OPCODE_LENGTH)) u_alu (
    .SrcA      (w_alu_a),
    .SrcB      (w_alu_b),
    .Operation (w_alu_op),
    .ALUResult (w_alu_res)
  );

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
  assign w_quo      = (r_sign_a ^ r_sign_b) ? -r_acc_lo : r_acc_lo;
  assign w_rem      = r_sign_a ? -r_acc_hi : r_acc_hi;

  always_comb begin
    w_fix_res = w_rem;
    case (r_f3)
      F3_MUL:                       w_fix_res = w_prod_fix[W-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix_res = w_prod_fix[2*W-1:W];
      F3_DIV, F3_DIVU:              w_fix_res = w_quo;
      default:                      w_fix_res = w_rem;
    endcase
  end

  always_comb begin
    if (w_div0) w_special_res = r_f3[1] ? r_a : '1;
    else        w_special_res = r_f3[1] ? '0  : r_a;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_f3           <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_acc_hi       <= '0;
      r_acc_lo       <= '0;
      r_result       <= '0;
      r_sign_a       <= 1'b0;
      r_sign_b       <= 1'b0;
      r_cnt          <= '0;
      r_start_ready  <= 1'b1;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else if (flush) begin
      r_state        <= IDLE;
      r_start_ready  <= 1'b1;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_f3          <= funct3;
            r_a           <= op_a;
            r_b           <= op_b;
            r_state       <= PREP;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        PREP: begin
          r_sign_a <= w_neg_a;
          r_sign_b <= w_neg_b;
          if (w_div0 || w_ovf) begin
            r_result       <= w_special_res;
            r_result_valid <= 1'b1;
            r_state        <= DONE;
          end else begin
            // The single alu negates A; B is negated locally in the same cycle.
            r_a      <= w_neg_a ? w_alu_res[W-1:0] : r_a;
            r_b      <= w_neg_b ? -r_b : r_b;
            r_acc_hi <= '0;
            if (w_is_div) r_acc_lo <= w_neg_a ? w_alu_res[W-1:0] : r_a;
            else          r_acc_lo <= w_neg_b ? -r_b : r_b;
            r_cnt    <= '0;
            r_state  <= ITER;
          end
        end
        ITER: begin
          if (w_is_div) begin
            r_acc_hi <= w_borrow ? w_rem_sh[W-1:0] : w_alu_res[W-1:0];
            r_acc_lo <= {r_acc_lo[W-2:0], ~w_borrow};
          end else begin
            r_acc_hi <= w_sum[W:1];
            r_acc_lo <= {w_sum[0], r_acc_lo[W-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_w'(W - 1)) r_state <= FIX;
        end
        FIX: begin
          r_result       <= w_fix_res;
          r_result_valid <= 1'b1;
          r_state        <= DONE;
        end
        DONE: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_start_ready  <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start_ready  = r_start_ready;
  assign result_valid = r_result_valid;
  assign result       = r_result;
  assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu_seq.sv
// ============================================================================
// tb_alu_mdu_seq : directed scoreboard bench for alu_mdu_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_mdu_seq;
  import mdu_pkg::*;

  logic        clk, reset, start_valid, start_ready, flush;
  logic        result_valid, result_ready, busy;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] sb[$];

  alu_mdu_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .funct3       (funct3),
    .op_a         (op_a),
    .op_b         (op_b),
    .flush        (flush),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE (called at posedge+1), wait for result_valid, score it.
  task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int  n;
    bit  busy_ok;
    start_valid = 1'b1; funct3 = f3; op_a = a; op_b = b;
    sb.push_back(exp);
    @(posedge clk); #1;
    start_valid = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    n = 1; busy_ok = 1'b1;
    while (!result_valid && n < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, "_result"}, result, sb.pop_front());
  endtask

  task automatic back_to_idle(input string tag);
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, {31'b0, result_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'b0, start_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] prod;
    bit          seen;

    reset = 1'b0; start_valid = 1'b0; flush = 1'b0; result_ready = 1'b1;
    funct3 = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_ready", {31'b0, start_ready}, 32'd1);
    chk("rst_result_valid", {31'b0, result_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    issue("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);            back_to_idle("mul");
    issue("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);  back_to_idle("mulh");
    issue("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35); back_to_idle("mulhu");
    issue("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 35);      back_to_idle("mulhsu");
    issue("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);            back_to_idle("div");
    issue("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);            back_to_idle("rem");
    issue("divu", F3_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 35);          back_to_idle("divu");
    issue("remu", F3_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1, 35);                  back_to_idle("remu");

    issue("div0", F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);                    back_to_idle("div0");
    issue("remu0", F3_REMU, 32'd5, 32'd0, 32'd5, 2);                          back_to_idle("remu0");
    issue("divovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);  back_to_idle("divovf");
    issue("removf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);          back_to_idle("removf");

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom | 32'd1;
      prod = {32'b0, ra} * {32'b0, rb};
      issue("rnd_mulhu", F3_MULHU, ra, rb, prod[63:32], 35); back_to_idle("rnd_mulhu");
      issue("rnd_divu", F3_DIVU, ra, rb, ra / rb, 35);       back_to_idle("rnd_divu");
    end

    // Backpressure: result held, new request ignored while DONE.
    result_ready = 1'b0;
    issue("bp", F3_DIVU, 32'd100, 32'd7, 32'd14, 35);
    start_valid = 1'b1; funct3 = F3_MUL; op_a = 32'd3; op_b = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_result", result, 32'd14);
      chk("bp_start_ready", {31'b0, start_ready}, 32'd0);
      chk("bp_valid", {31'b0, result_valid}, 32'd1);
    end
    start_valid = 1'b0; result_ready = 1'b1;
    back_to_idle("bp");
    issue("bp_next", F3_MUL, 32'd3, 32'd5, 32'd15, 35); back_to_idle("bp_next");

    // Flush at ITER count 10.
    start_valid = 1'b1; funct3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_start_ready", {31'b0, start_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", {31'b0, seen}, 32'd0);

    // Flush beats a simultaneous start in IDLE.
    start_valid = 1'b1; flush = 1'b1; funct3 = F3_MUL; op_a = 32'd2; op_b = 32'd2;
    @(posedge clk); #1;
    start_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_start_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-ITER.
    start_valid = 1'b1; funct3 = F3_MUL; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", {31'b0, result_valid}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_start_ready", {31'b0, start_ready}, 32'd1);
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    issue("post_rst", F3_MUL, 32'd6, 32'd7, 32'd42, 35); back_to_idle("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
